// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file target.
// Frame layout: R/W bit, address field, data field, MSB first.
package spi_regfile_pkg;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    READ_OUT
  } state_e;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// Two-flop synchroniser plus history flop for one async SPI pin.
// Emits the synchronised level and single-cycle rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Metastability chain followed by a history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file target, oversampled in the clk domain.
// Write frames commit on ncs rise; read frames return data on cipo.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int                NUM_REGS  = 5,
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(1 + ADDR_W);
  localparam logic [ADDR_W:0]  NREG      = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;

  sync_edge u_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk),
    .s_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge u_ncs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ncs),
    .s_o    (ncs_s),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  sync_edge u_copi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (copi),
    .s_o    (copi_s),
    .rise_o (copi_rise),
    .fall_o (copi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, ncs_s, copi_rise, copi_fall};

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FRAME_W-1:0]  shift_q;
  logic [DATA_W-1:0]   rd_q;
  logic                armed_q;
  logic                wr_strobe_q;
  logic                frame_err_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [FRAME_W-1:0]  shift_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   rd_d;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_data;
  logic                frame_ok;
  logic                addr_ok;
  logic                do_wr;
  logic                do_err;

  // Next shift/count values and the commit decision for the open frame
  always_comb begin
    shift_d  = {shift_q[FRAME_W-2:0], copi_s};
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    f_addr   = shift_q[DATA_W +: ADDR_W];
    f_data   = shift_q[DATA_W-1:0];
    frame_ok = (cnt_q == CNT_FRAME);
    addr_ok  = ({1'b0, f_addr} < NREG);
    do_wr    = ncs_rise & armed_q & (state_q == SHIFT) & frame_ok
             & (shift_q[FRAME_W-1] == OP_WRITE) & addr_ok;
    do_err   = ncs_rise & armed_q & (state_q != IDLE) & ~do_wr
             & ~((state_q == READ_OUT) & frame_ok);
  end

  // Read mux on the address just completed; out-of-range reads give 0
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_d[ADDR_W-1:0] == ADDR_W'(i)) rd_d = regs_q[i];
    end
  end

  // Frame FSM: ncs edges take priority over any coincident sclk edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rd_q        <= '0;
      armed_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_strobe_q <= do_wr;
      frame_err_q <= do_err;
      if (do_wr) begin
        wr_addr_q <= f_addr;
        wr_data_q <= f_data;
      end
      if (ncs_rise) begin
        state_q <= IDLE;
        armed_q <= 1'b1;
      end else if (ncs_fall) begin
        if (armed_q) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          shift_q <= '0;
        end
      end else if (sclk_rise) begin
        unique case (state_q)
          SHIFT: begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_HDR && shift_d[ADDR_W] == OP_READ) begin
              state_q <= READ_OUT;
              rd_q    <= rd_d;
            end
          end
          READ_OUT: cnt_q <= cnt_d;
          default: ;
        endcase
      end else if (sclk_fall && state_q == READ_OUT && cnt_q > CNT_HDR) begin
        // The fall right after the load keeps the MSB on the wire
        rd_q <= {rd_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Register file, written only by a fully validated write frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (do_wr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (f_addr == ADDR_W'(i)) regs_q[i] <= f_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo_oe   = (state_q == READ_OUT);
  assign cipo      = cipo_oe & rd_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: vector table plus write scoreboard.
// SCLK runs at clk/10; inputs change on clk falling edges.
module tb_spi_regfile_peripheral;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        ncs = 1'b1;
  logic        copi = 1'b0;
  logic        cipo;
  logic        cipo_oe;
  logic [39:0] regs_out;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_err;

  spi_regfile_peripheral dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int          nbits;
    logic [16:0] frame;
    bit          exp_wr;
    bit          exp_err;
    bit          is_rd;
    logic [7:0]  exp_rd;
    logic [39:0] exp_regs;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   n_strobe = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending write
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_err++;
      if (wr_strobe) begin
        wr_t e;
        n_strobe++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL strobe: unexpected addr %0h data %0h",
                   wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.a || wr_data !== e.d) begin
            bad++;
            $display("FAIL strobe: got %0h/%0h want %0h/%0h",
                     wr_addr, wr_data, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic hclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic c, output logic o);
    copi = b;
    hclk(5);
    c = cipo;
    o = cipo_oe;
    sclk = 1'b1;
    hclk(5);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [16:0] f, input int n,
                            input int gap,
                            output logic [15:0] cv,
                            output logic [15:0] ov);
    logic c;
    logic o;
    cv = '0;
    ov = '0;
    ncs = 1'b0;
    hclk(5);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(f[i], c, o);
      cv = {cv[14:0], c};
      ov = {ov[14:0], o};
    end
    hclk(5);
    ncs = 1'b1;
    hclk(gap);
  endtask

  initial begin
    logic [15:0] cv;
    logic [15:0] ov;
    logic        c;
    logic        o;
    int          s0;
    int          e0;

    vecs[0] = '{16, 17'({1'b1, 7'h04, 8'hA5}), 1, 0, 0, 8'h00,
                40'hA5_00_00_00_00};
    vecs[1] = '{15, 17'({1'b1, 7'h01, 7'h2A}), 0, 1, 0, 8'h00,
                40'hA5_00_00_00_00};
    vecs[2] = '{17, {1'b1, 7'h01, 8'h5A, 1'b1}, 0, 1, 0, 8'h00,
                40'hA5_00_00_00_00};
    vecs[3] = '{16, 17'({1'b1, 7'h10, 8'hFF}), 0, 1, 0, 8'h00,
                40'hA5_00_00_00_00};
    vecs[4] = '{16, 17'({1'b1, 7'h02, 8'h3C}), 1, 0, 0, 8'h00,
                40'hA5_00_3C_00_00};
    vecs[5] = '{16, 17'({1'b0, 7'h02, 8'h00}), 0, 0, 1, 8'h3C,
                40'hA5_00_3C_00_00};
    vecs[6] = '{16, 17'({1'b0, 7'h10, 8'h00}), 0, 0, 1, 8'h00,
                40'hA5_00_3C_00_00};
    vecs[7] = '{12, 17'({1'b0, 7'h02, 4'h0}), 0, 1, 0, 8'h00,
                40'hA5_00_3C_00_00};

    hclk(5);
    chk("rst_regs", 64'(regs_out), 64'h0);
    chk("rst_cipo", 64'({cipo, cipo_oe}), 64'h0);
    chk("rst_wr", 64'({wr_strobe, frame_err, wr_addr, wr_data}), 64'h0);
    rst = 1'b0;
    hclk(10);

    for (int v = 0; v < 8; v++) begin
      s0 = n_strobe;
      e0 = n_err;
      if (vecs[v].exp_wr)
        sb.push_back('{vecs[v].frame[14:8], vecs[v].frame[7:0]});
      send_frame(vecs[v].frame, vecs[v].nbits, 10, cv, ov);
      chk($sformatf("v%0d_strobe", v), 64'(n_strobe - s0),
          64'(vecs[v].exp_wr));
      chk($sformatf("v%0d_err", v), 64'(n_err - e0),
          64'(vecs[v].exp_err));
      chk($sformatf("v%0d_regs", v), 64'(regs_out),
          64'(vecs[v].exp_regs));
      chk($sformatf("v%0d_pend", v), 64'(sb.size()), 64'h0);
      if (vecs[v].is_rd) begin
        chk($sformatf("v%0d_rd", v), 64'(cv[7:0]), 64'(vecs[v].exp_rd));
        chk($sformatf("v%0d_oe", v), 64'(ov), 64'h00FF);
        chk($sformatf("v%0d_oe_end", v), 64'(cipo_oe), 64'h0);
      end
    end
    chk("wr_latched", 64'({wr_addr, wr_data}), 64'({7'h02, 8'h3C}));

    // Back-to-back writes separated by a 2-clk ncs-high gap
    s0 = n_strobe;
    sb.push_back('{7'h00, 8'h11});
    sb.push_back('{7'h03, 8'h33});
    send_frame(17'({1'b1, 7'h00, 8'h11}), 16, 2, cv, ov);
    send_frame(17'({1'b1, 7'h03, 8'h33}), 16, 10, cv, ov);
    chk("b2b_strobe", 64'(n_strobe - s0), 64'd2);
    chk("b2b_regs", 64'(regs_out), 64'hA5_33_3C_00_11);
    chk("b2b_pend", 64'(sb.size()), 64'h0);

    // Reset in the middle of a write frame discards it
    s0 = n_strobe;
    e0 = n_err;
    ncs = 1'b0;
    hclk(5);
    for (int i = 0; i < 8; i++) send_bit(i == 0, c, o);
    rst = 1'b1;
    hclk(1);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] d;
      d = 8'h55;
      send_bit(d[i], c, o);
    end
    hclk(5);
    ncs = 1'b1;
    hclk(10);
    chk("rstmid_strobe", 64'(n_strobe - s0), 64'd0);
    chk("rstmid_err", 64'(n_err - e0), 64'd0);
    chk("rstmid_regs", 64'(regs_out), 64'h0);

    sb.push_back('{7'h00, 8'h55});
    send_frame(17'({1'b1, 7'h00, 8'h55}), 16, 10, cv, ov);
    chk("post_rst_strobe", 64'(n_strobe - s0), 64'd1);
    chk("post_rst_regs", 64'(regs_out), 64'h55);
    chk("post_rst_pend", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
